// File: rtl/cpu_pkg.sv
// Shared definitions for the control sequencer: instruction field positions,
// opcode and ALU codes, FSM state encoding and opcode decode helpers.
package cpu_pkg;

  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 27;
  localparam int RA_MSB  = 26;
  localparam int RA_LSB  = 23;
  localparam int RB_MSB  = 22;
  localparam int RB_LSB  = 19;
  localparam int RC_MSB  = 18;
  localparam int RC_LSB  = 15;

  localparam logic [4:0] OPC_ADD = 5'b00011;
  localparam logic [4:0] OPC_SUB = 5'b00100;
  localparam logic [4:0] OPC_AND = 5'b00101;
  localparam logic [4:0] OPC_OR  = 5'b00110;

  typedef enum logic [3:0] {
    ALU_NOP = 4'b0000,
    ALU_ADD = 4'b0001,
    ALU_SUB = 4'b0010,
    ALU_AND = 4'b0011,
    ALU_OR  = 4'b0100
  } alu_op_e;

  typedef enum logic [2:0] {
    ST_T0   = 3'd0,
    ST_T1   = 3'd1,
    ST_T2   = 3'd2,
    ST_T3   = 3'd3,
    ST_T4   = 3'd4,
    ST_T5   = 3'd5,
    ST_HALT = 3'd6
  } state_e;

  function automatic alu_op_e alu_decode(input logic [4:0] opc);
    case (opc)
      OPC_ADD: return ALU_ADD;
      OPC_SUB: return ALU_SUB;
      OPC_AND: return ALU_AND;
      OPC_OR:  return ALU_OR;
      default: return ALU_NOP;
    endcase
  endfunction

  // Every legal opcode maps to a non-NOP ALU function.
  function automatic logic opcode_legal(input logic [4:0] opc);
    return alu_decode(opc) != ALU_NOP;
  endfunction

endpackage

// File: rtl/reg_select_decoder.sv
// 4-to-16 one-hot register select decoder with enable; all zero when disabled.
module reg_select_decoder (
  input  logic        en_i,
  input  logic [3:0]  sel_i,
  output logic [15:0] onehot_o
);

  always_comb begin
    onehot_o = '0;
    if (en_i) onehot_o[sel_i] = 1'b1;
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control unit: T0-T5 fetch/execute Moore FSM plus HALT on illegal opcode.
// Optional memory read handshake in T1 when CU_MEM_HANDSHAKE_EN is defined.
module control_sequencer
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        clr,
  input  logic        run,
  input  logic [31:0] ir,
  input  logic        mem_rdy,
  output logic        PCout,
  output logic        MARin,
  output logic        IncPC,
  output logic        Read,
  output logic        MDRin,
  output logic        MDRout,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin,
  output logic        Zlowout,
  output logic        PCin,
  output logic [15:0] Rout,
  output logic [15:0] Rin,
  output logic [3:0]  alu_op,
  output logic        done,
  output logic        halted
);

  state_e      state_q;
  logic [4:0]  opcode;
  logic [3:0]  ra, rb, rc;
  logic [3:0]  rout_sel;
  logic        rout_en;
  logic        rin_en;

  assign opcode = ir[OPC_MSB:OPC_LSB];
  assign ra     = ir[RA_MSB:RA_LSB];
  assign rb     = ir[RB_MSB:RB_LSB];
  assign rc     = ir[RC_MSB:RC_LSB];

`ifdef CU_MEM_HANDSHAKE_EN
  logic unused_sig;
  assign unused_sig = ^ir[RC_LSB-1:0];
`else
  logic unused_sig;
  assign unused_sig = ^{ir[RC_LSB-1:0], mem_rdy};
`endif

  always_ff @(posedge clk) begin
    // NOTE: clr is sampled on the clock edge only, so it has priority over run/mem_rdy here.
    if (clr) begin
      state_q <= ST_T0;
    end else begin
      case (state_q)
        ST_T0:   if (run) state_q <= ST_T1;
`ifdef CU_MEM_HANDSHAKE_EN
        ST_T1:   if (mem_rdy) state_q <= ST_T2;
`else
        ST_T1:   state_q <= ST_T2;
`endif
        ST_T2:   state_q <= ST_T3;
        ST_T3:   state_q <= opcode_legal(opcode) ? ST_T4 : ST_HALT;
        ST_T4:   state_q <= ST_T5;
        ST_T5:   state_q <= ST_T0;
        ST_HALT: state_q <= ST_HALT;
        default: state_q <= ST_T0;
      endcase
    end
  end

  // Rb feeds Y in T3, Rc feeds the ALU's second operand in T4.
  assign rout_sel = (state_q == ST_T3) ? rb : rc;
  assign rout_en  = !clr && ((state_q == ST_T3) || (state_q == ST_T4));
  assign rin_en   = !clr && (state_q == ST_T5);

  reg_select_decoder u_rout_dec (
    .en_i     (rout_en),
    .sel_i    (rout_sel),
    .onehot_o (Rout)
  );

  reg_select_decoder u_rin_dec (
    .en_i     (rin_en),
    .sel_i    (ra),
    .onehot_o (Rin)
  );

  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned (no latches).
    PCout   = 1'b0;
    MARin   = 1'b0;
    IncPC   = 1'b0;
    Read    = 1'b0;
    MDRin   = 1'b0;
    MDRout  = 1'b0;
    IRin    = 1'b0;
    Yin     = 1'b0;
    Zin     = 1'b0;
    Zlowout = 1'b0;
    PCin    = 1'b0;
    alu_op  = ALU_NOP;
    done    = 1'b0;
    halted  = 1'b0;
    if (!clr) begin
      case (state_q)
        ST_T0: begin
          PCout = 1'b1;
          MARin = 1'b1;
          IncPC = 1'b1;
          PCin  = 1'b1;
        end
        ST_T1: begin
          Read  = 1'b1;
          MDRin = 1'b1;
        end
        ST_T2: begin
          MDRout = 1'b1;
          IRin   = 1'b1;
        end
        ST_T3:   Yin = 1'b1;
        ST_T4: begin
          Zin    = 1'b1;
          alu_op = alu_decode(opcode);
        end
        ST_T5: begin
          Zlowout = 1'b1;
          done    = 1'b1;
        end
        ST_HALT: halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule
